mac_sequencer: RTL

- Parametrised controller for a neuron MAC datapath. It sequences N_NEURONS neurons of N_INPUTS terms each.
- For each neuron it drives the operand-load, accumulator-clear/enable and activation strobes, compensating for a pipelined multiplier of MUL_LAT stages.
- Results are presented through a valid/ready output handshake; the block sits between the top-level start/done interface and the multiplier/accumulator datapath.

---
 rtl/mac_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences a neuron MAC datapath.
// For each neuron: clear the accumulator, issue N_INPUTS operand loads,
// let the multiplier pipeline drain, strobe the activation register, then
// present the result with a valid/ready handshake. After the last neuron a
// one-cycle done pulse is emitted.
//
// Handshake: out_valid rises in OUT and stays high, with nrn_idx stable,
// until the cycle in which out_ready is also high; that cycle is the
// transfer. out_ready has no effect in any other state.
module mac_sequencer #(
    parameter int N_INPUTS  = 8,
    parameter int N_NEURONS = 4,
    parameter int IN_IDX_W  = 3,
    parameter int NRN_IDX_W = 2,
    parameter int MUL_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 out_ready,
    output logic                 ld_input,
    output logic                 ld_weight,
    output logic [IN_IDX_W-1:0]  in_idx,
    output logic [NRN_IDX_W-1:0] nrn_idx,
    output logic                 acc_clr,
    output logic                 acc_en,
    output logic                 act_en,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_ACT   = 3'd4,
        S_OUT   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Drain counter must hold values 0..MUL_LAT.
    localparam int DR_W = $clog2(MUL_LAT + 2);

    localparam logic [IN_IDX_W-1:0]  IN_LAST  = IN_IDX_W'(N_INPUTS - 1);
    localparam logic [NRN_IDX_W-1:0] NRN_LAST = NRN_IDX_W'(N_NEURONS - 1);
    localparam logic [DR_W-1:0]      DR_LAST  = DR_W'(MUL_LAT);

    state_t               state, state_nx;
    logic [IN_IDX_W-1:0]  in_cnt, in_cnt_nx;
    logic [NRN_IDX_W-1:0] nrn_cnt, nrn_cnt_nx;
    logic [DR_W-1:0]      dr_cnt, dr_cnt_nx;
    logic [MUL_LAT:0]     lat_sr;
    logic                 abort_hit;

    // abort only matters once a run is in progress.
    assign abort_hit = abort && (state != S_IDLE);

    // Load strobes travel through MUL_LAT+1 stages to become accumulate strobes.
    assign acc_en  = lat_sr[MUL_LAT];
    assign in_idx  = in_cnt;
    assign nrn_idx = nrn_cnt;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            in_cnt  <= '0;
            nrn_cnt <= '0;
            dr_cnt  <= '0;
        end else begin
            state   <= state_nx;
            in_cnt  <= in_cnt_nx;
            nrn_cnt <= nrn_cnt_nx;
            dr_cnt  <= dr_cnt_nx;
        end
    end

    // Latency shift register tracking the multiplier pipeline; flushed on abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_sr <= '0;
        end else if (abort_hit) begin
            lat_sr <= '0;
        end else begin
            lat_sr[0] <= ld_input;
            for (int k = 1; k <= MUL_LAT; k++) begin
                lat_sr[k] <= lat_sr[k-1];
            end
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_nx   = state;
        in_cnt_nx  = in_cnt;
        nrn_cnt_nx = nrn_cnt;
        dr_cnt_nx  = dr_cnt;
        ld_input   = 1'b0;
        ld_weight  = 1'b0;
        acc_clr    = 1'b0;
        act_en     = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != S_IDLE);
        done       = 1'b0;

        case (state)
            S_CLR:   acc_clr = 1'b1;
            S_ISSUE: begin
                ld_input  = 1'b1;
                ld_weight = 1'b1;
            end
            S_ACT:   act_en = 1'b1;
            S_OUT:   out_valid = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase

        if (abort_hit) begin
            state_nx   = S_IDLE;
            in_cnt_nx  = '0;
            nrn_cnt_nx = '0;
            dr_cnt_nx  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nx   = S_CLR;
                        nrn_cnt_nx = '0;
                        in_cnt_nx  = '0;
                    end
                end
                S_CLR: begin
                    state_nx  = S_ISSUE;
                    in_cnt_nx = '0;
                end
                S_ISSUE: begin
                    // in_idx holds at its last value through drain/act/out.
                    if (in_cnt == IN_LAST) begin
                        state_nx  = S_DRAIN;
                        dr_cnt_nx = '0;
                    end else begin
                        in_cnt_nx = in_cnt + IN_IDX_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (dr_cnt == DR_LAST) begin
                        state_nx = S_ACT;
                    end else begin
                        dr_cnt_nx = dr_cnt + DR_W'(1);
                    end
                end
                S_ACT: state_nx = S_OUT;
                S_OUT: begin
                    if (out_ready) begin
                        in_cnt_nx = '0;
                        if (nrn_cnt == NRN_LAST) begin
                            state_nx   = S_DONE;
                            nrn_cnt_nx = '0;
                        end else begin
                            state_nx   = S_CLR;
                            nrn_cnt_nx = nrn_cnt + NRN_IDX_W'(1);
                        end
                    end
                end
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

endmodule
